// File: rtl/reu_pkg.sv
// Shared definitions for the REU register file: register indices,
// transfer type encodings and bit positions inside the packed registers.
package reu_pkg;

  localparam logic [4:0] REG_STATUS  = 5'h00;
  localparam logic [4:0] REG_CMD     = 5'h01;
  localparam logic [4:0] REG_CALO    = 5'h02;
  localparam logic [4:0] REG_CAHI    = 5'h03;
  localparam logic [4:0] REG_REUALO  = 5'h04;
  localparam logic [4:0] REG_REUAMID = 5'h05;
  localparam logic [4:0] REG_REUAHI  = 5'h06;
  localparam logic [4:0] REG_LENLO   = 5'h07;
  localparam logic [4:0] REG_LENHI   = 5'h08;
  localparam logic [4:0] REG_INTMASK = 5'h09;
  localparam logic [4:0] REG_ADDRCTL = 5'h0A;

  typedef enum logic [1:0] {
    XFER_STASH  = 2'b00,
    XFER_FETCH  = 2'b01,
    XFER_SWAP   = 2'b10,
    XFER_VERIFY = 2'b11
  } xferType_t;

  // Status register (0x0) bit positions; bits 3:0 carry the version.
  localparam int ST_INTPEND = 7;
  localparam int ST_EOB     = 6;
  localparam int ST_FAULT   = 5;
  localparam int ST_SIZEJMP = 4;

  // Command register (0x1) bit positions; bits 1:0 carry the transfer type.
  localparam int CMD_EXEC     = 7;
  localparam int CMD_AUTOLOAD = 5;
  localparam int CMD_FF00DIS  = 4;

  // Interrupt mask register (0x9) bit positions.
  localparam int IM_INTEN = 7;
  localparam int IM_EOB   = 6;
  localparam int IM_VER   = 5;

  // Address control register (0xA): a set bit freezes that address.
  localparam int AC_FIXCA   = 7;
  localparam int AC_FIXREUA = 6;

endpackage

// File: rtl/reu_addr_counter.sv
// Address counter with a shadow copy used by autoload. Bytes are loaded
// individually from the register window; a load writes live and shadow.
module reu_addr_counter #(
  parameter int W = 16
) (
  input  logic         PHI2,
  input  logic         Reset,
  input  logic         Load,
  input  logic [1:0]   Lane,
  input  logic [7:0]   LoadData,
  input  logic         Step,
  input  logic         Hold,
  input  logic         Reload,
  output logic [W-1:0] Value
);

  logic [W-1:0] live;
  logic [W-1:0] shadow;
  logic [W-1:0] loadMask;
  logic [W-1:0] loadBits;

  // Position the incoming byte and its mask on the selected lane.
  always_comb begin
    loadMask = W'(8'hFF) << {Lane, 3'b000};
    loadBits = W'(LoadData) << {Lane, 3'b000};
  end

  // Register writes beat an autoload reload, which beats a normal step.
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      live   <= '0;
      shadow <= '0;
    end else if (Load) begin
      live   <= (live & ~loadMask) | loadBits;
      shadow <= (shadow & ~loadMask) | loadBits;
    end else if (Reload) begin
      live <= shadow;
    end else if (Step && !Hold) begin
      live <= live + W'(1);
    end
  end

  assign Value = live;

endmodule

// File: rtl/reu_dma_regs.sv
// REU register window at $DF00 plus the per-beat address/length sequencer
// that drives the DMA engine. All state changes on the falling PHI2 edge.
module reu_dma_regs
  import reu_pkg::*;
#(
  parameter int         REUA_W   = 19,
  parameter bit         SIZE_JMP = 1'b1,
  parameter logic [3:0] VERSION  = 4'h0
) (
  input  logic              PHI2,
  input  logic              Reset,
  input  logic              RegRD,
  input  logic              RegWR,
  input  logic [4:0]        A,
  input  logic [7:0]        WRD,
  output logic [7:0]        RDD,
  input  logic              Step,
  input  logic              VerifyErr,
  output logic              IRQ,
  output logic              ExecuteEN,
  output logic              FF00DecodeEN,
  output logic [1:0]        XferType,
  output logic [15:0]       CAOut,
  output logic [REUA_W-1:0] REUAOut,
  output logic              LastBeat
);

  logic        executeEn;
  logic        ff00DecodeEn;
  logic        autoload;
  xferType_t   xferType;
  logic        intPending;
  logic        eob;
  logic        fault;
  logic        intEnable;
  logic        eobMask;
  logic        verMask;
  logic [1:0]  incMode;
  logic [15:0] lenLive;
  logic [15:0] lenShadow;

  logic        lastBeatInt;
  logic        advEv;
  logic        termEv;
  logic        faultEv;
  logic        reloadEv;
  logic        statusRead;
  logic        caLoad;
  logic [1:0]  caLane;
  logic        reuaLoad;
  logic [1:0]  reuaLane;
  logic [15:0] caValue;
  logic [REUA_W-1:0] reuaValue;
  logic [23:0] reuaPad;

  // Beat events: a verify error swallows the step but not the terminal flag.
  always_comb begin
    lastBeatInt = (lenLive == 16'd1);
    advEv       = Step && executeEn && !VerifyErr;
    termEv      = Step && executeEn && lastBeatInt;
    faultEv     = VerifyErr && executeEn;
    reloadEv    = termEv && autoload;
    statusRead  = RegRD && (A == REG_STATUS);
    caLoad      = RegWR && ((A == REG_CALO) || (A == REG_CAHI));
    caLane      = {1'b0, (A == REG_CAHI)};
    reuaLoad    = RegWR && ((A == REG_REUALO) || (A == REG_REUAMID) || (A == REG_REUAHI));
    reuaLane    = (A == REG_REUAHI) ? 2'd2 : ((A == REG_REUAMID) ? 2'd1 : 2'd0);
  end

  reu_addr_counter #(.W(16)) caCounter (
    .PHI2     (PHI2),
    .Reset    (Reset),
    .Load     (caLoad),
    .Lane     (caLane),
    .LoadData (WRD),
    .Step     (advEv),
    .Hold     (incMode[1]),
    .Reload   (reloadEv),
    .Value    (caValue)
  );

  reu_addr_counter #(.W(REUA_W)) reuaCounter (
    .PHI2     (PHI2),
    .Reset    (Reset),
    .Load     (reuaLoad),
    .Lane     (reuaLane),
    .LoadData (WRD),
    .Step     (advEv),
    .Hold     (incMode[0]),
    .Reload   (reloadEv),
    .Value    (reuaValue)
  );

  // Transfer length down-counter; the terminal beat holds it at 1 unless reloaded.
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      lenLive   <= 16'hFFFF;
      lenShadow <= 16'hFFFF;
    end else if (RegWR && (A == REG_LENLO)) begin
      lenLive[7:0]   <= WRD;
      lenShadow[7:0] <= WRD;
    end else if (RegWR && (A == REG_LENHI)) begin
      lenLive[15:8]   <= WRD;
      lenShadow[15:8] <= WRD;
    end else if (reloadEv) begin
      lenLive <= lenShadow;
    end else if (advEv && !lastBeatInt) begin
      lenLive <= lenLive - 16'd1;
    end
  end

  // Command register: a CPU write wins; end of block or a fault disarms.
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      executeEn    <= 1'b0;
      ff00DecodeEn <= 1'b0;
      autoload     <= 1'b0;
      xferType     <= XFER_STASH;
    end else if (RegWR && (A == REG_CMD)) begin
      executeEn    <= WRD[CMD_EXEC];
      autoload     <= WRD[CMD_AUTOLOAD];
      ff00DecodeEn <= ~WRD[CMD_FF00DIS];
      xferType     <= xferType_t'(WRD[1:0]);
    end else if (termEv || faultEv) begin
      executeEn    <= 1'b0;
      ff00DecodeEn <= 1'b0;
    end
  end

  // Status flags: reading clears them, but an event on the same edge wins.
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      intPending <= 1'b0;
      eob        <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (termEv || faultEv) begin
        intPending <= 1'b1;
      end else if (statusRead) begin
        intPending <= 1'b0;
      end
      if (termEv) begin
        eob <= 1'b1;
      end else if (statusRead) begin
        eob <= 1'b0;
      end
      if (faultEv) begin
        fault <= 1'b1;
      end else if (statusRead) begin
        fault <= 1'b0;
      end
    end
  end

  // Interrupt mask and address-control registers, written only by the CPU.
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      intEnable <= 1'b0;
      eobMask   <= 1'b0;
      verMask   <= 1'b0;
      incMode   <= 2'b00;
    end else begin
      if (RegWR && (A == REG_INTMASK)) begin
        intEnable <= WRD[IM_INTEN];
        eobMask   <= WRD[IM_EOB];
        verMask   <= WRD[IM_VER];
      end
      if (RegWR && (A == REG_ADDRCTL)) begin
        incMode <= {WRD[AC_FIXCA], WRD[AC_FIXREUA]};
      end
    end
  end

  // Unimplemented REU address bits read back as ones.
  always_comb begin
    reuaPad = '1;
    reuaPad[REUA_W-1:0] = reuaValue;
  end

  // Read mux; unused and unimplemented bits return ones.
  always_comb begin
    RDD = 8'hFF;
    case (A)
      REG_STATUS: begin
        RDD = 8'h00;
        RDD[ST_INTPEND] = intPending;
        RDD[ST_EOB]     = eob;
        RDD[ST_FAULT]   = fault;
        RDD[ST_SIZEJMP] = SIZE_JMP;
        RDD[3:0]        = VERSION;
      end
      REG_CMD: begin
        RDD[CMD_EXEC]     = executeEn;
        RDD[CMD_AUTOLOAD] = autoload;
        RDD[CMD_FF00DIS]  = ~ff00DecodeEn;
        RDD[1:0]          = xferType;
      end
      REG_CALO:    RDD = caValue[7:0];
      REG_CAHI:    RDD = caValue[15:8];
      REG_REUALO:  RDD = reuaPad[7:0];
      REG_REUAMID: RDD = reuaPad[15:8];
      REG_REUAHI:  RDD = reuaPad[23:16];
      REG_LENLO:   RDD = lenLive[7:0];
      REG_LENHI:   RDD = lenLive[15:8];
      REG_INTMASK: begin
        RDD[IM_INTEN] = intEnable;
        RDD[IM_EOB]   = eobMask;
        RDD[IM_VER]   = verMask;
      end
      REG_ADDRCTL: begin
        RDD[AC_FIXCA]   = incMode[1];
        RDD[AC_FIXREUA] = incMode[0];
      end
      default: RDD = 8'hFF;
    endcase
  end

  assign IRQ          = intEnable && ((eob && eobMask) || (fault && verMask));
  assign ExecuteEN    = executeEn;
  assign FF00DecodeEN = ff00DecodeEn;
  assign XferType     = xferType;
  assign CAOut        = caValue;
  assign REUAOut      = reuaValue;
  assign LastBeat     = lastBeatInt;

endmodule

// File: tb/tb_reu_dma_regs.sv
// Bench for reu_dma_regs: directed scenarios followed by randomized
// transfers, all checked against a behavioural model of the register file.
module tb_reu_dma_regs;

  localparam int REUA_W   = 19;
  localparam int REUA_MOD = 1 << REUA_W;

  logic              PHI2 = 1'b1;
  logic              Reset = 1'b0;
  logic              RegRD = 1'b0;
  logic              RegWR = 1'b0;
  logic [4:0]        A = 5'd0;
  logic [7:0]        WRD = 8'd0;
  logic [7:0]        RDD;
  logic              Step = 1'b0;
  logic              VerifyErr = 1'b0;
  logic              IRQ;
  logic              ExecuteEN;
  logic              FF00DecodeEN;
  logic [1:0]        XferType;
  logic [15:0]       CAOut;
  logic [REUA_W-1:0] REUAOut;
  logic              LastBeat;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int mCa, mReua, mLen, sCa, sReua, sLen, mType, mInc;
  bit mExec, mAuto, mFf00, mIp, mEob, mFault, mIntEn, mEobM, mVerM;

  reu_dma_regs #(.REUA_W(REUA_W), .SIZE_JMP(1'b1), .VERSION(4'h0)) dut (
    .PHI2         (PHI2),
    .Reset        (Reset),
    .RegRD        (RegRD),
    .RegWR        (RegWR),
    .A            (A),
    .WRD          (WRD),
    .RDD          (RDD),
    .Step         (Step),
    .VerifyErr    (VerifyErr),
    .IRQ          (IRQ),
    .ExecuteEN    (ExecuteEN),
    .FF00DecodeEN (FF00DecodeEN),
    .XferType     (XferType),
    .CAOut        (CAOut),
    .REUAOut      (REUAOut),
    .LastBeat     (LastBeat)
  );

  always #5 PHI2 = ~PHI2;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int byteSet(input int v, input int lane, input int d);
    return (v & ~(255 << (8 * lane))) | ((d & 255) << (8 * lane));
  endfunction

  function automatic int expRead(input int a);
    case (a)
      0: return (mIp ? 128 : 0) + (mEob ? 64 : 0) + (mFault ? 32 : 0) + 16;
      1: return (mExec ? 128 : 0) + 64 + (mAuto ? 32 : 0) + (mFf00 ? 0 : 16) + 12 + mType;
      2: return mCa & 255;
      3: return (mCa >> 8) & 255;
      4: return mReua & 255;
      5: return (mReua >> 8) & 255;
      6: return ((mReua >> 16) | ~((1 << (REUA_W - 16)) - 1)) & 255;
      7: return mLen & 255;
      8: return (mLen >> 8) & 255;
      9: return (mIntEn ? 128 : 0) + (mEobM ? 64 : 0) + (mVerM ? 32 : 0) + 31;
      10: return mInc * 64 + 63;
      default: return 255;
    endcase
  endfunction

  task automatic modelReset();
    mCa = 0; mReua = 0; mLen = 65535; sCa = 0; sReua = 0; sLen = 65535;
    mExec = 0; mAuto = 0; mFf00 = 0; mType = 0;
    mIp = 0; mEob = 0; mFault = 0; mIntEn = 0; mEobM = 0; mVerM = 0; mInc = 0;
  endtask

  // One falling edge of the model, from the register-level rules.
  task automatic modelEdge(input bit rd, input bit wr, input int a, input int d,
                           input bit st, input bit ve, input bit rs);
    bit last, term, flt, adv;
    if (rs) begin
      modelReset();
      return;
    end
    last = (mLen == 1);
    term = st && mExec && last;
    flt  = ve && mExec;
    adv  = st && mExec && !ve;
    if (wr && (a == 2 || a == 3)) begin
      mCa = byteSet(mCa, a - 2, d); sCa = byteSet(sCa, a - 2, d);
    end else if (term && mAuto) mCa = sCa;
    else if (adv && (mInc & 2) == 0) mCa = (mCa + 1) % 65536;
    if (wr && (a >= 4 && a <= 6)) begin
      mReua = byteSet(mReua, a - 4, d) % REUA_MOD; sReua = byteSet(sReua, a - 4, d) % REUA_MOD;
    end else if (term && mAuto) mReua = sReua;
    else if (adv && (mInc & 1) == 0) mReua = (mReua + 1) % REUA_MOD;
    if (wr && (a == 7 || a == 8)) begin
      mLen = byteSet(mLen, a - 7, d); sLen = byteSet(sLen, a - 7, d);
    end else if (term && mAuto) mLen = sLen;
    else if (adv && !last) mLen = (mLen + 65535) % 65536;
    if (wr && a == 1) begin
      mExec = ((d >> 7) & 1) != 0;
      mAuto = ((d >> 5) & 1) != 0;
      mFf00 = ((d >> 4) & 1) == 0;
      mType = d & 3;
    end else if (term || flt) begin
      mExec = 0; mFf00 = 0;
    end
    if (term || flt) mIp = 1; else if (rd && a == 0) mIp = 0;
    if (term) mEob = 1; else if (rd && a == 0) mEob = 0;
    if (flt) mFault = 1; else if (rd && a == 0) mFault = 0;
    if (wr && a == 9) begin
      mIntEn = ((d >> 7) & 1) != 0; mEobM = ((d >> 6) & 1) != 0; mVerM = ((d >> 5) & 1) != 0;
    end
    if (wr && a == 10) mInc = (d >> 6) & 3;
  endtask

  task automatic checkOutput();
    bit expIrq;
    expIrq = mIntEn && ((mEob && mEobM) || (mFault && mVerM));
    check("IRQ", IRQ, expIrq);
    check("ExecuteEN", ExecuteEN, mExec);
    check("FF00DecodeEN", FF00DecodeEN, mFf00);
    check("XferType", XferType, mType);
    check("CAOut", CAOut, mCa);
    check("REUAOut", REUAOut, mReua);
    check("LastBeat", LastBeat, mLen == 1);
    check("RDD", RDD, expRead(int'(A)));
  endtask

  // Drive one bus cycle, let the falling edge happen, then compare everything.
  task automatic applyStimulus(input bit rd, input bit wr, input int a, input int d,
                               input bit st, input bit ve, input bit rs);
    RegRD = rd; RegWR = wr; A = 5'(a); WRD = 8'(d); Step = st; VerifyErr = ve; Reset = rs;
    #1;
    if (rd) check("readData", RDD, expRead(a));
    modelEdge(rd, wr, a, d, st, ve, rs);
    @(negedge PHI2);
    #1;
    RegRD = 0; RegWR = 0; Step = 0; VerifyErr = 0; Reset = 0;
    checkOutput();
  endtask

  task automatic peekLit(input string tag, input int a, input int exp);
    @(posedge PHI2);
    A = 5'(a);
    #1;
    check(tag, RDD, exp);
    check("peekModel", RDD, expRead(a));
  endtask

  task automatic setupXfer(input int ca, input int reua, input int len, input int cmd);
    applyStimulus(0, 1, 2, ca & 255, 0, 0, 0);
    applyStimulus(0, 1, 3, (ca >> 8) & 255, 0, 0, 0);
    applyStimulus(0, 1, 4, reua & 255, 0, 0, 0);
    applyStimulus(0, 1, 5, (reua >> 8) & 255, 0, 0, 0);
    applyStimulus(0, 1, 6, (reua >> 16) & 255, 0, 0, 0);
    applyStimulus(0, 1, 7, len & 255, 0, 0, 0);
    applyStimulus(0, 1, 8, (len >> 8) & 255, 0, 0, 0);
    applyStimulus(0, 1, 1, cmd, 0, 0, 0);
  endtask

  initial begin
    int len, cmd;
    bit rd, wr, st, ve;
    int a, d;
    modelReset();

    // Reset and register map defaults
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) begin
      @(posedge PHI2);
      A = 5'(i);
      #1;
      check("resetMap", RDD, expRead(i));
    end
    peekLit("rstStatus", 0, 8'h10);
    peekLit("rstReuaHi", 6, 8'hF8);
    peekLit("rstLenLo", 7, 8'hFF);
    peekLit("rstLenHi", 8, 8'hFF);
    peekLit("rstIntMask", 9, 8'h1F);
    peekLit("rstAddrCtl", 10, 8'h3F);
    peekLit("rstUnused", 11, 8'hFF);
    peekLit("rstLast", 31, 8'hFF);

    // Plain transfer with REU address wrapping at 19 bits
    setupXfer(16'h1000, 32'h7FFFE, 3, 8'h80);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    check("reuaStep1", REUAOut, 19'h7FFFF);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    check("reuaWrap", REUAOut, 19'h00000);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    check("caEnd", CAOut, 16'h1003);
    check("execEnd", ExecuteEN, 1'b0);
    check("lastHeld", LastBeat, 1'b1);
    peekLit("eobStatus", 0, 8'hD0);
    peekLit("lenHeldLo", 7, 8'h01);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Autoload restores the programmed transfer
    setupXfer(16'h1000, 32'h7FFFE, 3, 8'hA0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 0, 0);
    check("autoCa", CAOut, 16'h1000);
    check("autoReua", REUAOut, 19'h7FFFE);
    peekLit("autoLen", 7, 8'h03);
    peekLit("autoStatus", 0, 8'hD0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Fixed addresses, then a full 65536-beat transfer
    applyStimulus(0, 1, 10, 8'hC0, 0, 0, 0);
    setupXfer(16'h1234, 32'h12345, 2, 8'h80);
    repeat (2) applyStimulus(0, 0, 0, 0, 1, 0, 0);
    check("fixedCa", CAOut, 16'h1234);
    check("fixedReua", REUAOut, 19'h12345);
    peekLit("fixedStatus", 0, 8'hD0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 7, 0, 0, 0, 0);
    applyStimulus(0, 1, 8, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 8'h80, 0, 0, 0);
    for (int i = 0; i < 65536; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      if (i < 65535) check("eobEarly", RDD[6], 1'b0);
      else check("eobAt65536", RDD[6], 1'b1);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 10, 0, 0, 0, 0);

    // Verify error on beat 2 of 5
    applyStimulus(0, 1, 9, 8'hA0, 0, 0, 0);
    setupXfer(16'h2000, 32'h00100, 5, 8'h83);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    check("faultIrq", IRQ, 1'b1);
    check("faultExec", ExecuteEN, 1'b0);
    peekLit("faultLen", 7, 8'h04);
    peekLit("faultStatus", 0, 8'hB0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    peekLit("clearedStatus", 0, 8'h10);
    check("clearedIrq", IRQ, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Status read on the same edge as the terminal beat
    setupXfer(16'h3000, 32'h00200, 1, 8'h80);
    peekLit("preEventStatus", 0, 8'h10);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    peekLit("setWinsStatus", 0, 8'hD0);
    check("eobNoIrq", IRQ, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a transfer
    setupXfer(16'h4000, 32'h00300, 5, 8'hB3);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    check("midRstCa", CAOut, 16'h0000);
    check("midRstReua", REUAOut, 19'h00000);
    check("midRstExec", ExecuteEN, 1'b0);
    peekLit("midRstLen", 7, 8'hFF);
    peekLit("midRstStatus", 0, 8'h10);
    peekLit("midRstMask", 9, 8'h1F);

    // Randomized transfers against the model
    for (int t = 0; t < 60; t++) begin
      applyStimulus(0, 1, 9, int'($urandom) & 8'hE0, 0, 0, 0);
      applyStimulus(0, 1, 10, int'($urandom) & 8'hC0, 0, 0, 0);
      len = int'($urandom_range(1, 6));
      cmd = 8'h80 | (int'($urandom) & 8'h33);
      setupXfer(int'($urandom) & 16'hFFFF, int'($urandom) % REUA_MOD, len, cmd);
      for (int c = 0; c < 10; c++) begin
        rd = ($urandom % 8) == 0;
        wr = ($urandom % 20) == 0;
        st = ($urandom % 4) != 0;
        ve = ($urandom % 16) == 0;
        a  = rd ? 0 : (wr ? 1 : int'($urandom_range(0, 15)));
        d  = int'($urandom) & 8'h7F;
        applyStimulus(rd, wr, a, d, st, ve, 0);
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
